// File: rtl/mix_seq_ctrl.sv
// mix_seq_ctrl: actuation sequencer for an N-inlet iterative mixing chain.
// Each iteration opens every inlet in turn for its dwell, then runs the
// mixer, then flushes the outlet. Phases of length 0 are skipped without
// spending a cycle, so the next non-empty phase always starts back-to-back.
//
// Handshake: start is a level sampled only in IDLE (and only when abort is
// low). It is accepted on that edge, and the first actuation output appears
// in the following cycle. done is a single-cycle pulse, registered, that
// appears in the cycle after the last active cycle. abort is sampled on any
// edge and returns the block to IDLE on that edge.
module mix_seq_ctrl #(
  parameter int NUM_SOLN = 3,
  parameter int CNT_W    = 16,
  parameter int ITER_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_SOLN*CNT_W-1:0] dwell_cfg,
  input  logic [CNT_W-1:0]          mix_cycles,
  input  logic [CNT_W-1:0]          flush_cycles,
  input  logic [ITER_W-1:0]         iterations,
  output logic [NUM_SOLN-1:0]       valve_en,
  output logic                      mix_en,
  output logic                      flush_en,
  output logic                      busy,
  output logic                      done,
  output logic [ITER_W-1:0]         iter_count
);

  // Schedule positions: 0..NUM_SOLN-1 are inlets, then MIX, then FLUSH.
  localparam int NPOS = NUM_SOLN + 2;
  localparam int PW   = $clog2(NPOS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MIX,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                    state, state_n;
  logic [PW-1:0]             pos, pos_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [ITER_W-1:0]         iter_n;
  logic                      latch;

  logic [NUM_SOLN*CNT_W-1:0] dwell_sh;
  logic [CNT_W-1:0]          mix_sh;
  logic [CNT_W-1:0]          flush_sh;
  logic [ITER_W-1:0]         iters_sh;

  logic [CNT_W-1:0]          dur [NPOS];
  logic                      all_found, aft_found, go_tgt;
  logic [PW-1:0]             all_pos, aft_pos, tgt;
  logic [ITER_W-1:0]         iter_inc;

  // Phase durations: live inputs while idle (the start edge), shadows otherwise.
  always_comb begin
    for (int p = 0; p < NUM_SOLN; p++) begin
      dur[p] = (state == S_IDLE) ? dwell_cfg[p*CNT_W +: CNT_W]
                                 : dwell_sh[p*CNT_W +: CNT_W];
    end
    dur[NUM_SOLN]   = (state == S_IDLE) ? mix_cycles   : mix_sh;
    dur[NUM_SOLN+1] = (state == S_IDLE) ? flush_cycles : flush_sh;
  end

  // First non-empty phase of an iteration, and first one after the current.
  always_comb begin
    all_found = 1'b0;
    all_pos   = '0;
    aft_found = 1'b0;
    aft_pos   = '0;
    for (int p = 0; p < NPOS; p++) begin
      if (!all_found && dur[p] != '0) begin
        all_found = 1'b1;
        all_pos   = PW'(p);
      end
      if (!aft_found && p > int'(pos) && dur[p] != '0) begin
        aft_found = 1'b1;
        aft_pos   = PW'(p);
      end
    end
  end

  // Next-state logic: phase countdown, zero-skip chaining, iteration wrap.
  always_comb begin
    state_n  = state;
    pos_n    = pos;
    cnt_n    = cnt;
    iter_n   = iter_count;
    latch    = 1'b0;
    go_tgt   = 1'b0;
    tgt      = '0;
    iter_inc = iter_count + ITER_W'(1);
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          latch  = 1'b1;
          iter_n = '0;
          if (iterations == '0) begin
            state_n = S_DONE;
          end else if (!all_found) begin
            // Every phase empty: all iterations complete in zero cycles.
            state_n = S_DONE;
            iter_n  = iterations;
          end else begin
            go_tgt = 1'b1;
            tgt    = all_pos;
          end
        end
      end
      S_LOAD, S_MIX, S_FLUSH: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (aft_found) begin
          go_tgt = 1'b1;
          tgt    = aft_pos;
        end else begin
          iter_n = iter_inc;
          if (iter_inc == iters_sh) begin
            state_n = S_DONE;
          end else begin
            go_tgt = 1'b1;
            tgt    = all_pos;
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (go_tgt) begin
      pos_n = tgt;
      cnt_n = dur[tgt] - CNT_W'(1);
      if (int'(tgt) < NUM_SOLN)       state_n = S_LOAD;
      else if (int'(tgt) == NUM_SOLN) state_n = S_MIX;
      else                            state_n = S_FLUSH;
    end
  end

  // State, counters, config shadows and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pos        <= '0;
      cnt        <= '0;
      iter_count <= '0;
      dwell_sh   <= '0;
      mix_sh     <= '0;
      flush_sh   <= '0;
      iters_sh   <= '0;
      valve_en   <= '0;
      mix_en     <= 1'b0;
      flush_en   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pos        <= pos_n;
      cnt        <= cnt_n;
      iter_count <= iter_n;
      if (latch) begin
        dwell_sh <= dwell_cfg;
        mix_sh   <= mix_cycles;
        flush_sh <= flush_cycles;
        iters_sh <= iterations;
      end
      valve_en <= (state_n == S_LOAD) ? (NUM_SOLN'(1) << pos_n) : '0;
      mix_en   <= (state_n == S_MIX);
      flush_en <= (state_n == S_FLUSH);
      busy     <= (state_n != S_IDLE);
      done     <= (state_n == S_DONE);
    end
  end

endmodule
